// File: rtl/seq_logic_pkg.sv
// Shared opcode encodings and FSM state type for the sliced logic unit.
package seq_logic_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_ORN  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit eight-way bitwise operator.
module logic_slice
  import seq_logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] r_s
);

  always_comb begin
    r_s = '0;
    case (op)
      OP_AND:  r_s = a_s & b_s;
      OP_OR:   r_s = a_s | b_s;
      OP_XOR:  r_s = a_s ^ b_s;
      OP_NOR:  r_s = ~(a_s | b_s);
      OP_XNOR: r_s = ~(a_s ^ b_s);
      OP_NAND: r_s = ~(a_s & b_s);
      OP_ANDN: r_s = a_s & ~b_s;
      OP_ORN:  r_s = a_s | ~b_s;
      default: r_s = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: processes SLICE bits per clock and commits
// the full result with zero/parity flags in a single cycle.
module seq_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             parity
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_param_check
    $error("seq_logic_unit: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, work, work_nx;
  logic [IW-1:0]    base;
  logic [SLICE-1:0] r_s;
  logic             accept, last;

  assign ready  = (state_q == IDLE);
  assign accept = ready && start;
  assign last   = (cnt == LAST);
  assign base   = IW'(cnt) * IW'(SLICE);

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_s (a_q[base +: SLICE]),
    .b_s (b_q[base +: SLICE]),
    .op  (op_q),
    .r_s (r_s)
  );

  // Work value including the slice being produced this cycle, so the
  // completion edge can commit the full result without an extra cycle.
  always_comb begin
    work_nx = work;
    work_nx[base +: SLICE] = r_s;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      work   <= '0;
      r      <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
        cnt  <= '0;
      end else if (state_q == RUN) begin
        work <= work_nx;
        cnt  <= cnt + 1'b1;
        if (last) begin
          r      <= work_nx;
          zero   <= ~|work_nx;
          parity <= ^work_nx;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
